// File: rtl/spi_slave_fsm.sv
// SPI mode-0 (CPOL=0, CPHA=0) target endpoint with a register-port back end.
//
// SCK, CS_N and MOSI are oversampled in the i_clk domain through SYNC_STAGES-deep
// synchronizers. Each frame starts with a command byte. Its MSB selects read (1) or
// write (0), and its low ADDR_W bits give the start address. Any number of data bytes
// follow, and the address auto-increments (wrapping) after every byte.
//
// Ports:
//   i_clk, i_rst_n   system clock, asynchronous active-low reset
//   i_sck, i_cs_n    SPI clock / chip select from the master (asynchronous)
//   i_mosi           SPI data, master -> slave (sampled on SCK rise)
//   o_miso           SPI data, slave -> master (changes on SCK fall)
//   o_miso_oe        pad output enable for MISO
//   o_addr           register address of the current access
//   o_wr_en          1-clk write strobe, o_wr_data valid with it
//   o_wr_data        write data
//   o_rd_req         1-clk read request; i_rd_data is sampled exactly one clock later
//   i_rd_data        read data from the register port
//   o_busy           frame in progress
//   o_frame_err      1-clk pulse when CS is released in the middle of a byte
module spi_slave_fsm #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sck,
  input  logic              i_cs_n,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic              o_miso_oe,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_wr_en,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_rd_req,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_busy,
  output logic              o_frame_err
);

  localparam int unsigned CntW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StWrData,
    StRdLoad,
    StRdData
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------
  // CS_N resets to the asserted level. A master already holding CS low across
  // reset therefore produces no falling edge, so the rest of that frame is ignored.
  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_prev_q, cs_prev_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], i_sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_rise, cs_fall;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // SCK edges only count while CS is asserted.
  assign sck_rise = sck_s & ~sck_prev_q & ~cs_s;
  assign sck_fall = ~sck_s & sck_prev_q & ~cs_s;
  assign cs_fall  = ~cs_s & cs_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;

  // ---------------------------------------------------------------------------
  // Frame FSM with registered outputs
  // ---------------------------------------------------------------------------
  state_e            state_q;
  logic [CntW-1:0]   bit_cnt_q;
  logic [DATA_W-1:0] rx_q;
  logic [DATA_W-1:0] tx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              wr_en_q;
  logic              rd_req_q;
  logic              rd_wait_q;    // high the clock after o_rd_req: i_rd_data is valid now
  logic              miso_q;
  logic              frame_err_q;
  logic [DATA_W-1:0] rx_next;
  logic              last_bit;

  assign rx_next  = {rx_q[DATA_W-2:0], mosi_s};
  assign last_bit = (bit_cnt_q == LastBit);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      rd_req_q    <= 1'b0;
      rd_wait_q   <= 1'b0;
      miso_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_en_q     <= 1'b0;
      rd_req_q    <= 1'b0;
      frame_err_q <= 1'b0;
      rd_wait_q   <= rd_req_q;

      // A write bumps the address one clock after its strobe.
      if (wr_en_q) begin
        addr_q <= addr_q + ADDR_W'(1);
      end

      if (cs_rise) begin
        // End of frame wins over any SCK edge seen in the same clock.
        // A partial byte is dropped, and any outstanding read prefetch is abandoned.
        frame_err_q <= (state_q != StIdle) && (bit_cnt_q != '0);
        state_q     <= StIdle;
        bit_cnt_q   <= '0;
        miso_q      <= 1'b0;
        rd_wait_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (cs_fall) begin
              state_q   <= StCmd;
              bit_cnt_q <= '0;
              rx_q      <= '0;
              tx_q      <= '0;
              miso_q    <= 1'b0;
            end
          end

          StCmd: begin
            miso_q <= 1'b0;
            if (sck_rise) begin
              rx_q <= rx_next;
              if (last_bit) begin
                bit_cnt_q <= '0;
                addr_q    <= rx_next[ADDR_W-1:0];
                if (rx_next[DATA_W-1]) begin
                  state_q  <= StRdLoad;
                  rd_req_q <= 1'b1;
                end else begin
                  state_q <= StWrData;
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + CntW'(1);
              end
            end
          end

          StWrData: begin
            miso_q <= 1'b0;
            if (sck_rise) begin
              rx_q <= rx_next;
              if (last_bit) begin
                bit_cnt_q <= '0;
                wr_data_q <= rx_next;
                wr_en_q   <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + CntW'(1);
              end
            end
          end

          StRdLoad: begin
            // o_miso keeps the previous byte's last bit until the next fall.
            // At the minimum SCK half-period, the load can land in the same clock as
            // that fall. In that case the MSB goes straight out.
            if (rd_wait_q) begin
              state_q <= StRdData;
              if (sck_fall) begin
                miso_q <= i_rd_data[DATA_W-1];
                tx_q   <= i_rd_data << 1;
              end else begin
                tx_q <= i_rd_data;
              end
            end
          end

          StRdData: begin
            if (sck_fall) begin
              miso_q <= tx_q[DATA_W-1];
              tx_q   <= tx_q << 1;
            end
            if (sck_rise) begin
              if (last_bit) begin
                bit_cnt_q <= '0;
                addr_q    <= addr_q + ADDR_W'(1);
                rd_req_q  <= 1'b1;
                state_q   <= StRdLoad;
              end else begin
                bit_cnt_q <= bit_cnt_q + CntW'(1);
              end
            end
          end

          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign o_miso      = miso_q;
  assign o_miso_oe   = (state_q != StIdle) & ~cs_s;
  assign o_addr      = addr_q;
  assign o_wr_en     = wr_en_q;
  assign o_wr_data   = wr_data_q;
  assign o_rd_req    = rd_req_q;
  assign o_busy      = (state_q != StIdle);
  assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Directed bench for spi_slave_fsm. A behavioural SPI master drives the pins.
// The bench builds queues of the register accesses each frame must produce, and a
// per-clock compare process checks the DUT's strobes against them.
module tb_spi_slave_fsm;
  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = 7;
  localparam int unsigned SS   = 2;
  localparam int unsigned HALF = 4;  // SCK half-period in clk cycles

  logic          clk = 1'b0;
  logic          rst_n, sck, cs_n, mosi;
  logic          miso, miso_oe, wr_en, rd_req, busy, frame_err;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data, rd_data;
  logic [DW-1:0] regs [128];

  spi_slave_fsm #(.DATA_W(DW), .ADDR_W(AW), .SYNC_STAGES(SS)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_sck      (sck),
    .i_cs_n     (cs_n),
    .i_mosi     (mosi),
    .o_miso     (miso),
    .o_miso_oe  (miso_oe),
    .o_addr     (addr),
    .o_wr_en    (wr_en),
    .o_wr_data  (wr_data),
    .o_rd_req   (rd_req),
    .i_rd_data  (rd_data),
    .o_busy     (busy),
    .o_frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // The register file holds the address stable while a read is in flight.
  assign rd_data = regs[addr];

  int            checks   = 0;
  int            failures = 0;
  logic [14:0]   exp_wr[$];   // {addr, data}
  logic [AW-1:0] exp_rd[$];
  int            exp_err = 0;
  int            seen_err = 0;
  bit            idle_expect = 1'b1;
  bit            wr_frame = 1'b0;
  time           last_rise = 0;
  logic [14:0]   e_wr;
  logic [AW-1:0] e_rd;
  logic [DW-1:0] r0, r1, dummy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Per-clock compare against the expectation queues.
  always @(posedge clk) begin
    #1;
    chk("oe_implies_busy", 32'(miso_oe & ~busy), 32'd0);
    if (wr_en) begin
      if (exp_wr.size() == 0) begin
        chk("unexpected_wr_en", 32'd1, 32'd0);
      end else begin
        e_wr = exp_wr.pop_front();
        chk("wr_addr", 32'(addr), 32'(e_wr[14:8]));
        chk("wr_data", 32'(wr_data), 32'(e_wr[7:0]));
        chk("wr_latency", 32'(($time - last_rise > 20) && ($time - last_rise <= 31)), 32'd1);
      end
    end
    if (rd_req) begin
      if (exp_rd.size() == 0) begin
        chk("unexpected_rd_req", 32'd1, 32'd0);
      end else begin
        e_rd = exp_rd.pop_front();
        chk("rd_req_addr", 32'(addr), 32'(e_rd));
      end
    end
    if (frame_err) seen_err++;
    if (idle_expect) chk("idle_quiet", 32'({busy, miso_oe, wr_en, rd_req, frame_err}), 32'd0);
    if (wr_frame) chk("miso_low_in_write", 32'(miso), 32'd0);
  end

  // Master shifts out the top n bits of tx, MSB first, and samples MISO at each rise.
  task automatic xfer_n(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      repeat (HALF) @(negedge clk);
      rx[7-i] = miso;
      sck = 1'b1;
      last_rise = $time;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic start_frame();
    @(negedge clk);
    cs_n = 1'b0;
    idle_expect = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic end_frame();
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    idle_expect = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_miso_oe"}, 32'(miso_oe), 32'd0);
    chk({tag, "_miso"}, 32'(miso), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_rd_req"}, 32'(rd_req), 32'd0);
    chk({tag, "_addr"}, 32'(addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) regs[i] = 8'(i * 7 + 1);
    regs[3] = 8'h3C;
    regs[4] = 8'hC3;
    rst_n = 1'b0;
    sck   = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Single write 0x05 <- 0xA5.
    exp_wr.push_back({7'h05, 8'hA5});
    wr_frame = 1'b1;
    start_frame();
    xfer_n(8'h05, 8, dummy);
    xfer_n(8'hA5, 8, dummy);
    end_frame();
    wr_frame = 1'b0;

    // Burst write from 0x7F wraps to 0x00.
    exp_wr.push_back({7'h7F, 8'h11});
    exp_wr.push_back({7'h00, 8'h22});
    wr_frame = 1'b1;
    start_frame();
    xfer_n(8'h7F, 8, dummy);
    xfer_n(8'h11, 8, dummy);
    xfer_n(8'h22, 8, dummy);
    end_frame();
    wr_frame = 1'b0;

    // Read two bytes from 3. The prefetch at address 5 is issued before CS rises.
    exp_rd.push_back(7'd3);
    exp_rd.push_back(7'd4);
    exp_rd.push_back(7'd5);
    start_frame();
    xfer_n(8'h83, 8, dummy);
    xfer_n(8'h00, 8, r0);
    chk("mid_read_oe", 32'(miso_oe), 32'd1);
    chk("mid_read_busy", 32'(busy), 32'd1);
    xfer_n(8'h00, 8, r1);
    end_frame();
    chk("read_byte0", 32'(r0), 32'h3C);
    chk("read_byte1", 32'(r1), 32'hC3);

    // Write aborted after 5 data bits: no strobe, one error pulse.
    exp_err++;
    wr_frame = 1'b1;
    start_frame();
    xfer_n(8'h10, 8, dummy);
    xfer_n(8'hFF, 5, dummy);
    end_frame();
    wr_frame = 1'b0;

    // Reset in the middle of a read with CS held low.
    exp_rd.push_back(7'h10);
    start_frame();
    xfer_n(8'h90, 8, dummy);
    xfer_n(8'h00, 4, dummy);
    rst_n = 1'b0;
    idle_expect = 1'b1;
    #1;
    chk_all_zero("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    xfer_n(8'h12, 8, dummy);   // CS still low: must be ignored
    xfer_n(8'h34, 8, dummy);
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    exp_wr.push_back({7'h22, 8'h5A});
    wr_frame = 1'b1;
    start_frame();
    xfer_n(8'h22, 8, dummy);
    xfer_n(8'h5A, 8, dummy);
    end_frame();
    wr_frame = 1'b0;

    // SCK toggling at clk/4 with CS high.
    for (int i = 0; i < 12; i++) begin
      sck  = 1'b1;
      mosi = ~mosi;
      repeat (2) @(negedge clk);
      sck = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (6) @(negedge clk);

    chk("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    chk("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    chk("frame_err_pulses", 32'(seen_err), 32'(exp_err));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
